// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared states, default timing constants and width helper for
//               the UART transmit scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_GAP     = 2'd3
    } tx_state_t;

    localparam int c_DEFAULT_GAP_CYC     = 434;
    localparam int c_DEFAULT_TIMEOUT_CYC = 50000;

    // Index width that stays legal (at least one bit) for a single requester.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter; the search starts one past
//               the previous winner and wraps around.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_last_grant,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_grant_idx
);

    int   w_dist;
    int   w_best;
    int   w_sel;
    logic w_found;

    // Distance from the slot after the last winner; smallest valid distance wins.
    always_comb begin
        w_dist  = 0;
        w_best  = 0;
        w_sel   = 0;
        w_found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_dist = (i + NUM_REQ - 1 - int'(i_last_grant)) % NUM_REQ;
            if (i_req[i] && (!w_found || (w_dist < w_best))) begin
                w_found = 1'b1;
                w_best  = w_dist;
                w_sel   = i;
            end
        end
    end

    always_comb begin
        o_grant = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            o_grant[i] = w_found && (w_sel == i);
        end
        o_grant_idx = ID_W'(w_sel);
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_sched
// Description : Shares one UART transmitter among NUM_REQ byte requesters with
//               round-robin grants, handshake timeouts and inter-byte gaps.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int GAP_CYC     = c_DEFAULT_GAP_CYC,
    parameter int TIMEOUT_CYC = c_DEFAULT_TIMEOUT_CYC
) (
    input  logic                           clock_50mhz,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [8*NUM_REQ-1:0]           req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [7:0]                     uart_data,
    output logic                           uart_run,
    input  logic                           uart_feedback,
    output logic                           tx_done,
    output logic                           tx_err,
    output logic [idx_width(NUM_REQ)-1:0]  tx_id,
    output logic                           busy
);

    localparam int c_ID_W  = idx_width(NUM_REQ);
    localparam int c_TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int c_GAP_W = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
    localparam logic [c_TO_W-1:0]  c_TO_LAST  = c_TO_W'(TIMEOUT_CYC - 1);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    logic [1:0]         r_rst_sync;
    logic               w_rst_n;
    logic               r_fb_meta;
    logic               r_fb_s;
    tx_state_t          r_state;
    tx_state_t          w_next_state;
    logic [c_TO_W-1:0]  r_phase_cnt;
    logic [c_GAP_W-1:0] r_gap_cnt;
    logic [c_ID_W-1:0]  r_last_grant;
    logic [7:0]         r_uart_data;
    logic [c_ID_W-1:0]  r_tx_id;
    logic               r_tx_done;
    logic               r_tx_err;
    logic [NUM_REQ-1:0] w_arb_grant;
    logic [c_ID_W-1:0]  w_arb_idx;
    logic [7:0]         w_sel_data;
    logic               w_take;
    logic               w_done_set;
    logic               w_err_set;
    logic               w_phase_last;
    logic               w_gap_last;

    // Assertion is immediate; deassertion is retimed onto clock_50mhz.
    always_ff @(posedge clock_50mhz or negedge rst_n) begin
        if (!rst_n) r_rst_sync <= '0;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    always_ff @(posedge clock_50mhz or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_fb_meta <= 1'b0;
            r_fb_s    <= 1'b0;
        end else begin
            r_fb_meta <= uart_feedback;
            r_fb_s    <= r_fb_meta;
        end
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (c_ID_W)
    ) u_arb (
        .i_req        (req_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_arb_grant),
        .o_grant_idx  (w_arb_idx)
    );

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_arb_grant[i]) w_sel_data = req_data[8*i +: 8];
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_take       = 1'b0;
        w_done_set   = 1'b0;
        w_err_set    = 1'b0;
        w_phase_last = (r_phase_cnt == c_TO_LAST);
        w_gap_last   = (GAP_CYC == 0) || (r_gap_cnt == c_GAP_LAST);
        case (r_state)
            ST_IDLE: begin
                if (w_rst_n && (|req_valid)) begin
                    w_take       = 1'b1;
                    w_next_state = ST_SEND;
                end
            end
            ST_SEND: begin
                if (r_fb_s) begin
                    w_next_state = ST_RELEASE;
                end else if (w_phase_last) begin
                    w_err_set    = 1'b1;
                    w_next_state = ST_GAP;
                end
            end
            ST_RELEASE: begin
                if (!r_fb_s) begin
                    w_done_set   = 1'b1;
                    w_next_state = ST_GAP;
                end else if (w_phase_last) begin
                    w_err_set    = 1'b1;
                    w_next_state = ST_GAP;
                end
            end
            ST_GAP: begin
                if (w_gap_last) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_50mhz or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state      <= ST_IDLE;
            r_phase_cnt  <= '0;
            r_gap_cnt    <= '0;
            r_last_grant <= c_ID_W'(NUM_REQ - 1);
            r_uart_data  <= '0;
            r_tx_id      <= '0;
            r_tx_done    <= 1'b0;
            r_tx_err     <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_tx_done <= w_done_set;
            r_tx_err  <= w_err_set;
            if (w_take) begin
                r_uart_data  <= w_sel_data;
                r_tx_id      <= w_arb_idx;
                r_last_grant <= w_arb_idx;
            end
            // Each handshake phase gets its own full timeout window.
            if (w_next_state != r_state) begin
                r_phase_cnt <= '0;
            end else if (((r_state == ST_SEND) || (r_state == ST_RELEASE)) && !w_phase_last) begin
                r_phase_cnt <= r_phase_cnt + 1'b1;
            end
            if (r_state != ST_GAP) begin
                r_gap_cnt <= '0;
            end else if (!w_gap_last) begin
                r_gap_cnt <= r_gap_cnt + 1'b1;
            end
        end
    end

    assign req_ready = w_arb_grant & {NUM_REQ{w_take}};
    assign uart_data = r_uart_data;
    assign uart_run  = (r_state == ST_SEND);
    assign tx_done   = r_tx_done;
    assign tx_err    = r_tx_err;
    assign tx_id     = r_tx_id;
    assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire
